// File: rtl/jt900h_opqueue.sv
// Instruction prefetch queue: fetches 16-bit words into a byte FIFO and presents a 32-bit opcode window.
// Optional sticky underflow detection is enabled by defining JT900H_OPQ_UFLOW_EN.
module jt900h_opqueue #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        pc_load,
    input  logic [23:0] pc_new,
    input  logic [2:0]  fetched,
    output logic [31:0] op,
    output logic        op_ok,
    output logic [2:0]  op_cnt,
    output logic [23:0] pc,
    output logic [23:0] bus_addr,
    output logic        bus_rd,
    input  logic [15:0] bus_din,
    input  logic        bus_ok,
    output logic        uflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    r_buf [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_count;
    logic [23:0]   r_pc;
    logic [23:0]   r_fa;
    logic          r_bus_rd;
    logic [31:0]   r_op;
    logic          r_op_ok;
    logic [2:0]    r_op_cnt;

    logic          w_accept;
    logic [1:0]    w_yield;
    logic [1:0]    w_wr_n;
    logic [2:0]    w_eff;
    logic [CW-1:0] w_count_next;
    logic [AW-1:0] w_rd_next;
    logic [AW-1:0] w_wr_next;
    logic [23:0]   w_fa_next;
    logic [1:0]    w_yield_next;
    logic          w_rd_req;
    logic [7:0]    w_buf_next [DEPTH];
    logic [31:0]   w_op_next;
    logic [2:0]    w_op_cnt_next;

    // Next-state datapath; the opcode window is built from post-update contents
    always_comb begin
        w_accept      = r_bus_rd & bus_ok;
        w_yield       = r_fa[0] ? 2'd1 : 2'd2;
        w_wr_n        = w_accept ? w_yield : 2'd0;
        w_eff         = (CW'(fetched) > r_count) ? 3'(r_count) : fetched;
        w_count_next  = r_count + CW'(w_wr_n) - CW'(w_eff);
        w_rd_next     = r_rd + AW'(w_eff);
        w_wr_next     = r_wr + AW'(w_wr_n);
        w_fa_next     = r_fa + 24'(w_wr_n);
        w_yield_next  = w_fa_next[0] ? 2'd1 : 2'd2;
        w_rd_req      = (CW'(DEPTH) - w_count_next) >= CW'(w_yield_next);
        w_buf_next    = r_buf;
        if (w_accept) begin
            if (r_fa[0]) begin
                w_buf_next[r_wr] = bus_din[15:8];
            end else begin
                w_buf_next[r_wr]           = bus_din[7:0];
                w_buf_next[r_wr + AW'(1)]  = bus_din[15:8];
            end
        end
        w_op_next = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (CW'(i) < w_count_next)
                w_op_next[8*i +: 8] = w_buf_next[w_rd_next + AW'(i)];
        end
        w_op_cnt_next = (w_count_next >= CW'(4)) ? 3'd4 : 3'(w_count_next);
    end

    // Storage array carries no reset; contents are qualified by the count
    always_ff @(posedge clk) begin
        if (!rst && cen && !pc_load && w_accept) begin
            for (int i = 0; i < int'(DEPTH); i++)
                r_buf[i] <= w_buf_next[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd     <= '0;
            r_wr     <= '0;
            r_count  <= '0;
            r_pc     <= 24'd0;
            r_fa     <= 24'd0;
            r_bus_rd <= 1'b0;
            r_op     <= 32'd0;
            r_op_ok  <= 1'b0;
            r_op_cnt <= 3'd0;
        end else if (cen) begin
            if (pc_load) begin
                // Flush: in-flight data and consumption this cycle are dropped
                r_rd     <= '0;
                r_wr     <= '0;
                r_count  <= '0;
                r_pc     <= pc_new;
                r_fa     <= pc_new;
                r_bus_rd <= 1'b0;
                r_op     <= 32'd0;
                r_op_ok  <= 1'b0;
                r_op_cnt <= 3'd0;
            end else begin
                r_rd     <= w_rd_next;
                r_wr     <= w_wr_next;
                r_count  <= w_count_next;
                r_pc     <= r_pc + 24'(w_eff);
                r_fa     <= w_fa_next;
                r_bus_rd <= w_rd_req;
                r_op     <= w_op_next;
                r_op_ok  <= w_count_next >= CW'(4);
                r_op_cnt <= w_op_cnt_next;
            end
        end
    end

`ifdef JT900H_OPQ_UFLOW_EN
    logic r_uflow;
    logic w_uf;

    assign w_uf = CW'(fetched) > r_count;

    // Sticky until reset or a new stream is loaded
    always_ff @(posedge clk) begin
        if (rst) begin
            r_uflow <= 1'b0;
        end else if (cen) begin
            if (pc_load) begin
                r_uflow <= 1'b0;
            end else if (w_uf) begin
                r_uflow <= 1'b1;
`ifndef SYNTHESIS
                $display("jt900h_opqueue: underflow pc=%06h fetched=%0d count=%0d",
                         r_pc, fetched, r_count);
`endif
            end
        end
    end

    assign uflow = r_uflow;
`else
    assign uflow = 1'b0;
`endif

    assign op       = r_op;
    assign op_ok    = r_op_ok;
    assign op_cnt   = r_op_cnt;
    assign pc       = r_pc;
    assign bus_addr = {r_fa[23:1], 1'b0};
    assign bus_rd   = r_bus_rd;

endmodule

// File: tb/tb_jt900h_opqueue.sv
// Bench for jt900h_opqueue: directed scenarios plus random traffic against a byte-queue reference model.
module tb_jt900h_opqueue;

    localparam int unsigned DEPTH = 8;

    logic        clk;
    logic        rst;
    logic        cen;
    logic        pc_load;
    logic [23:0] pc_new;
    logic [2:0]  fetched;
    logic [31:0] op;
    logic        op_ok;
    logic [2:0]  op_cnt;
    logic [23:0] pc;
    logic [23:0] bus_addr;
    logic        bus_rd;
    logic [15:0] bus_din;
    logic        bus_ok;
    logic        uflow;

    jt900h_opqueue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cen(cen), .pc_load(pc_load), .pc_new(pc_new),
        .fetched(fetched), .op(op), .op_ok(op_ok), .op_cnt(op_cnt), .pc(pc),
        .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_din(bus_din), .bus_ok(bus_ok),
        .uflow(uflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int step_no = 0;

    // Reference model: queue of bytes, program counter, fetch address, pending request
    logic [7:0]  q[$];
    logic [23:0] m_pc;
    logic [23:0] m_fa;
    bit          m_rd;
    bit          m_uf;

    // Bus slave state
    logic [15:0] ovr [bit [23:0]];
    int          wait_cfg = 0;
    int          wait_left = 0;
    bit          rand_wait = 0;

    function automatic logic [7:0] byte_at(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    function automatic logic [15:0] mem_word(input logic [23:0] a);
        if (ovr.exists(a)) return ovr[a];
        return {byte_at(a | 24'd1), byte_at(a)};
    endfunction

    function automatic int next_wait();
        return rand_wait ? int'($urandom_range(0, 2)) : wait_cfg;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s step=%0d: observed %h expected %h", tag, step_no, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc = 24'd0;
        m_fa = 24'd0;
        m_rd = 1'b0;
        m_uf = 1'b0;
    endtask

    task automatic model_apply(input bit pl, input logic [23:0] pn, input logic [2:0] f,
                               input bit ok, input logic [15:0] d);
        int eff;
        int y;
        if (pl) begin
            q.delete();
            m_pc = pn;
            m_fa = pn;
            m_rd = 1'b0;
            m_uf = 1'b0;
            return;
        end
        eff = (int'(f) > q.size()) ? q.size() : int'(f);
`ifdef JT900H_OPQ_UFLOW_EN
        if (int'(f) > q.size()) m_uf = 1'b1;
`endif
        repeat (eff) void'(q.pop_front());
        m_pc = m_pc + 24'(eff);
        if (m_rd && ok) begin
            if (m_fa[0]) begin
                q.push_back(d[15:8]);
                m_fa = m_fa + 24'd1;
            end else begin
                q.push_back(d[7:0]);
                q.push_back(d[15:8]);
                m_fa = m_fa + 24'd2;
            end
        end
        y = m_fa[0] ? 1 : 2;
        m_rd = (int'(DEPTH) - q.size()) >= y;
    endtask

    task automatic compare_all();
        logic [31:0] e_op;
        e_op = 32'd0;
        for (int i = 0; i < 4; i++)
            if (i < q.size()) e_op[8*i +: 8] = q[i];
        chk("op", op, e_op);
        chk("op_cnt", 32'(op_cnt), (q.size() > 4) ? 32'd4 : 32'(q.size()));
        chk("op_ok", 32'(op_ok), 32'(q.size() >= 4));
        chk("pc", 32'(pc), 32'(m_pc));
        chk("bus_rd", 32'(bus_rd), 32'(m_rd));
        if (m_rd) chk("bus_addr", 32'(bus_addr), 32'({m_fa[23:1], 1'b0}));
        chk("uflow", 32'(uflow), 32'(m_uf));
    endtask

    // One clock: slave answers from the model's view of the request, model advances, outputs checked
    task automatic step(input bit pl, input logic [23:0] pn, input logic [2:0] f,
                        input bit c, input bit fok);
        bit          ok;
        bit          prev_rd;
        logic [15:0] d;
        prev_rd = m_rd;
        ok = fok || (m_rd && wait_left == 0);
        d  = m_rd ? mem_word({m_fa[23:1], 1'b0}) : 16'($urandom);
        pc_load = pl;
        pc_new  = pn;
        fetched = f;
        cen     = c;
        bus_ok  = ok;
        bus_din = d;
        if (rst) model_reset();
        else if (c) model_apply(pl, pn, f, ok, d);
        @(posedge clk);
        #1;
        step_no++;
        if (rst) wait_left = next_wait();
        else if (c) begin
            if (pl || !prev_rd || ok) wait_left = next_wait();
            else wait_left--;
        end
        compare_all();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 24'd0, 3'd0, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1; cen = 1'b0; pc_load = 1'b0; pc_new = 24'd0;
        fetched = 3'd0; bus_din = 16'd0; bus_ok = 1'b0;
        model_reset();

        // Reset, even start address, zero-wait fill to full
        idle(2);
        rst = 1'b0;
        chk("rst_op", op, 32'd0);
        chk("rst_bus_addr", 32'(bus_addr), 32'd0);
        ovr[24'h000100] = 16'h3412;
        ovr[24'h000102] = 16'h7856;
        step(1'b1, 24'h000100, 3'd0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            idle(1);
            chk("t1_bus_rd", 32'(bus_rd), 32'd1);
            chk("t1_bus_addr", 32'(bus_addr), 32'h100 + 32'(2 * k));
            if (k == 2) begin
                chk("t1_op", op, 32'h78563412);
                chk("t1_op_ok", 32'(op_ok), 32'd1);
                chk("t1_pc", 32'(pc), 32'h000100);
            end
        end
        idle(1);
        chk("t1_full_rd", 32'(bus_rd), 32'd0);
        idle(2);

        // Odd start address yields one byte from the first word
        ovr[24'h000100] = 16'hAA11;
        ovr[24'h000102] = 16'h3322;
        step(1'b1, 24'h000101, 3'd0, 1'b1, 1'b0);
        idle(2);
        chk("t2_op1", op, 32'h000000AA);
        chk("t2_cnt1", 32'(op_cnt), 32'd1);
        chk("t2_pc", 32'(pc), 32'h000101);
        idle(1);
        chk("t2_op3", op, 32'h003322AA);
        chk("t2_cnt3", 32'(op_cnt), 32'd3);

        // Drain a full queue four bytes at a time while refilling
        idle(4);
        step(1'b0, 24'd0, 3'd4, 1'b1, 1'b0);
        chk("t3_pc", 32'(pc), 32'h000105);
        chk("t3_op0", 32'(op[7:0]), 32'(byte_at(24'h000105)));
        repeat (8) step(1'b0, 24'd0, 3'd4, 1'b1, 1'b0);

        // Slow slave aborted by a jump; late data in the jump cycle is dropped
        wait_cfg = 3;
        step(1'b1, 24'h001000, 3'd0, 1'b1, 1'b0);
        idle(3);
        step(1'b1, 24'h002000, 3'd0, 1'b1, 1'b1);
        chk("t4_rd_drop", 32'(bus_rd), 32'd0);
        chk("t4_cnt", 32'(op_cnt), 32'd0);
        wait_cfg = 0;
        idle(1);
        chk("t4_addr", 32'(bus_addr), 32'h002000);
        idle(1);
        chk("t4_op", op, {16'd0, mem_word(24'h002000)});

        // Address wrap at the top of the 24-bit space, then a clock-enable freeze
        step(1'b1, 24'hFFFFFE, 3'd0, 1'b1, 1'b0);
        idle(2);
        chk("t5_fa_wrap", 32'(bus_addr), 32'h000000);
        idle(1);
        step(1'b0, 24'd0, 3'd2, 1'b1, 1'b0);
        chk("t5_pc_wrap", 32'(pc), 32'h000000);
        chk("t5_op0", 32'(op[7:0]), 32'(byte_at(24'h000000)));
        for (int k = 0; k < 5; k++) begin
            step(k == 2, 24'h123456, 3'd3, 1'b0, 1'b1);
            chk("t5_hold_pc", 32'(pc), 32'h000000);
        end
        idle(2);

        // Underflow: one byte held, consumer asks for three
        step(1'b1, 24'h003001, 3'd0, 1'b1, 1'b0);
        idle(1);
        wait_cfg = 5;
        idle(1);
        chk("t6_cnt1", 32'(op_cnt), 32'd1);
        step(1'b0, 24'd0, 3'd3, 1'b1, 1'b0);
        chk("t6_pc", 32'(pc), 32'h003002);
        chk("t6_cnt0", 32'(op_cnt), 32'd0);
`ifdef JT900H_OPQ_UFLOW_EN
        chk("t6_uflow", 32'(uflow), 32'd1);
        idle(1);
        chk("t6_sticky", 32'(uflow), 32'd1);
`else
        chk("t6_uflow", 32'(uflow), 32'd0);
        idle(1);
`endif
        step(1'b1, 24'h004000, 3'd0, 1'b1, 1'b0);
        chk("t6_clear", 32'(uflow), 32'd0);
        wait_cfg = 0;

        // Random traffic
        rand_wait = 1;
        for (int i = 0; i < 600; i++) begin
            logic [23:0] pn;
            pn  = (i % 3 == 0) ? (24'hFFFFF8 + 24'($urandom_range(0, 7))) : 24'($urandom);
            rst = (i == 300);
            step($urandom_range(0, 39) == 0, pn, 3'($urandom_range(0, 4)),
                 $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0);
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
